// File: rtl/serial_rx4_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_rx4_pkg
// Description : State encodings, default frame width and counter-width helper
//               shared by the serial receiver and its upstream controller.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_rx4_pkg;

  // Frame state encodings; 2'd3 is unused and decoded as idle.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_STOP = 2'd2
  } rx_state_t;

  // Default number of data bits per frame.
  localparam int c_DEFAULT_WIDTH = 4;

  // Bit-counter width: clog2 of the frame width, never narrower than 1 bit.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/serial_rx4_bitcnt.sv
`default_nettype none
// ============================================================================
// Module      : serial_rx4_bitcnt
// Description : Enable-gated bit counter with synchronous clear and a
//               terminal-count flag. Saturates at the terminal value.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_rx4_bitcnt #(
  parameter int WIDTH = 2,
  parameter int TERM  = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tc
);

  localparam logic [WIDTH-1:0] c_TERM = WIDTH'(TERM);

  logic [WIDTH-1:0] r_count;
  logic             w_tc;

  assign w_tc = (r_count == c_TERM);
  assign o_tc = w_tc;

  // Count enabled edges; clear wins over enable, and the count holds at the
  // terminal value so it can never wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && !w_tc) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/serial_rx4.sv
`default_nettype none
// ============================================================================
// Module      : serial_rx4
// Description : LSB-first serial-to-parallel receiver with start/stop framing,
//               advancing one bit per enabled clock (shiftEN).
// Revision    : 1.0 - initial release
// ============================================================================
module serial_rx4
  import serial_rx4_pkg::*;
#(
  parameter int DATA_WIDTH = c_DEFAULT_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  shiftEN,
  input  logic                  Q,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  valid,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int c_CNT_W = cnt_width(DATA_WIDTH);

  rx_state_t             r_state;
  rx_state_t             w_next_state;
  logic [DATA_WIDTH-1:0] r_shreg;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;
  logic                  r_frame_err;
  logic                  r_busy;

  logic                  w_cnt_clr;
  logic                  w_cnt_en;
  logic                  w_cnt_tc;
  logic                  w_shift;
  logic                  w_load;
  logic                  w_ferr;

  serial_rx4_bitcnt #(
    .WIDTH (c_CNT_W),
    .TERM  (DATA_WIDTH - 1)
  ) u_bitcnt (
    .clk   (clk),
    .rst   (reset),
    .i_en  (w_cnt_en),
    .i_clr (w_cnt_clr),
    .o_tc  (w_cnt_tc)
  );

  // Frame state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and per-edge actions; nothing advances without shiftEN.
  always_comb begin
    w_next_state = r_state;
    w_cnt_clr    = 1'b0;
    w_cnt_en     = 1'b0;
    w_shift      = 1'b0;
    w_load       = 1'b0;
    w_ferr       = 1'b0;
    case (r_state)
      ST_DATA: begin
        if (shiftEN) begin
          w_shift  = 1'b1;
          w_cnt_en = 1'b1;
          if (w_cnt_tc) begin
            w_next_state = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        if (shiftEN) begin
          w_load       = Q;
          w_ferr       = !Q;
          w_next_state = ST_IDLE;
        end
      end
      default: begin
        // Idle, and also the unused encoding: wait for a start bit.
        if (shiftEN && !Q) begin
          w_cnt_clr    = 1'b1;
          w_next_state = ST_DATA;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
    endcase
  end

  // Shift register, output word and one-cycle strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shreg     <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      if (w_shift) begin
        r_shreg <= {Q, r_shreg[DATA_WIDTH-1:1]};
      end
      if (w_load) begin
        r_data <= r_shreg;
      end
      r_valid     <= w_load;
      r_frame_err <= w_ferr;
      r_busy      <= (w_next_state == ST_DATA) || (w_next_state == ST_STOP);
    end
  end

  assign data      = r_data;
  assign valid     = r_valid;
  assign frame_err = r_frame_err;
  assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_serial_rx4.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_rx4
// Description : Randomized scoreboard bench for serial_rx4. The driver builds
//               frames from words and pushes the expected strobe; a monitor
//               pops and compares whenever the receiver strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_rx4;

  localparam int W = 4;

  logic         clk;
  logic         reset;
  logic         shiftEN;
  logic         Q;
  logic [W-1:0] data;
  logic         valid;
  logic         frame_err;
  logic         busy;

  typedef struct {
    logic         err;
    logic [W-1:0] word;
    int           cyc;
  } exp_t;

  exp_t         sb[$];
  int           cyc;
  int           checks;
  int           errors;
  logic [W-1:0] exp_data;
  logic         exp_busy;

  serial_rx4 #(.DATA_WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .shiftEN   (shiftEN),
    .Q         (Q),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge index, used to timestamp expected strobes.
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compares steady outputs every cycle and pops on each strobe.
  always @(negedge clk) begin
    exp_t e;
    checks++;
    if (data !== exp_data) begin
      errors++;
      $display("FAIL data_hold cyc=%0d got=%h exp=%h", cyc, data, exp_data);
    end
    checks++;
    if (busy !== exp_busy) begin
      errors++;
      $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, exp_busy);
    end
    if (valid !== 1'b0 || frame_err !== 1'b0) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe cyc=%0d valid=%b frame_err=%b exp=none",
                 cyc, valid, frame_err);
      end else begin
        e = sb.pop_front();
        if (valid !== !e.err || frame_err !== e.err || e.cyc != cyc) begin
          errors++;
          $display("FAIL strobe cyc=%0d valid=%b frame_err=%b exp_valid=%b exp_err=%b exp_cyc=%0d",
                   cyc, valid, frame_err, !e.err, e.err, e.cyc);
        end
      end
    end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
      checks++;
      errors++;
      e = sb.pop_front();
      $display("FAIL missing_strobe cyc=%0d got=none exp_err=%b exp_cyc=%0d",
               cyc, e.err, e.cyc);
    end
  end

  // One bit on the line: optional disabled cycles carrying noise, then one
  // enabled cycle that the receiver samples.
  task automatic send_bit(input logic b, input int gmin, input int gmax);
    repeat ($urandom_range(gmax, gmin)) begin
      @(negedge clk);
      shiftEN = 1'b0;
      Q       = 1'($urandom);
    end
    @(negedge clk);
    shiftEN = 1'b1;
    Q       = b;
    @(posedge clk);
    #1;
  endtask

  // Whole frame: start, LSB-first word, stop. Expected strobe is queued once
  // the stop bit has been sampled.
  task automatic send_frame(input logic [W-1:0] w, input logic stop,
                            input int gmin, input int gmax);
    send_bit(1'b0, gmin, gmax);
    exp_busy = 1'b1;
    for (int i = 0; i < W; i++) send_bit(w[i], gmin, gmax);
    send_bit(stop, gmin, gmax);
    exp_busy = 1'b0;
    if (stop) exp_data = w;
    sb.push_back('{err: !stop, word: w, cyc: cyc});
  endtask

  // Idle line: high, enable random.
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      shiftEN = 1'($urandom);
      Q       = 1'b1;
    end
  endtask

  task automatic do_reset(input int n);
    #1;
    reset    = 1'b1;
    exp_busy = 1'b0;
    exp_data = '0;
    repeat (n) @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  // Global time bound.
  initial begin
    #400000;
    $display("FAIL timeout cyc=%0d got=running exp=finished", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] w;
    cyc      = 0;
    checks   = 0;
    errors   = 0;
    exp_data = '0;
    exp_busy = 1'b0;
    reset    = 1'b1;
    shiftEN  = 1'b1;
    Q        = 1'b1;

    // Reset held with line idle and strobe active.
    repeat (20) @(posedge clk);
    #2;
    reset = 1'b0;
    idle(3);

    // Good frame 4'hB, no gaps.
    send_frame(4'hB, 1'b1, 0, 0);
    idle(2);

    // Framing error: stop bit low, data must keep 4'hB.
    send_frame(4'hA, 1'b0, 0, 0);
    idle(2);

    // Gated strobe: enabled every third cycle, noise in between.
    send_frame(4'h6, 1'b1, 2, 2);
    idle(3);

    // Back-to-back frames, no idle gap.
    send_frame(4'hA, 1'b1, 0, 0);
    send_frame(4'h5, 1'b1, 0, 0);
    idle(2);

    // Reset after the second data bit, then a clean frame.
    send_bit(1'b0, 0, 0);
    exp_busy = 1'b1;
    send_bit(1'b1, 0, 0);
    send_bit(1'b1, 0, 0);
    do_reset(2);
    idle(2);
    send_frame(4'h3, 1'b1, 0, 0);
    idle(2);

    // Line held low: all-zero word then framing error.
    send_frame(4'h0, 1'b0, 0, 0);
    idle(2);

    // Randomized frames with random gating and idle spacing.
    for (int n = 0; n < 60; n++) begin
      w = W'($urandom);
      send_frame(w, ($urandom_range(9, 0) != 0), 0, $urandom_range(2, 0));
      idle($urandom_range(3, 0));
    end

    idle(6);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got=%0d exp=0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/serial_rx4.md
# serial_rx4

Serial-to-parallel receiver that consumes the bit stream produced by the 4-bit parallel-load shift register stage. That stage emits LSB first, and its line idles high because it shifts in 1s. This block detects a start bit, shifts in `DATA_WIDTH` data bits, and checks a stop bit. It then presents the recovered word with a one-cycle valid strobe, or a one-cycle framing-error strobe. It advances only on the same `shiftEN` strobe that drives the upstream register, so both stages move one bit per enabled clock.

## Interface
- `DATA_WIDTH`, default 4: data bits per frame.
- `clk`  input  1: single clock; all state changes on rising edge.
- `reset`  input  1: asynchronous, active-high reset.
- `shiftEN`  input  1: bit strobe; state and shift register advance only on edges where it is 1.
- `Q`  input  1: serial line from the upstream shift register.
- `data`  output  DATA_WIDTH: last correctly framed word; holds until the next good frame.
- `valid`  output  1: one-cycle pulse, high exactly one cycle after the edge that sampled a good stop bit.
- `frame_err`  output  1: one-cycle pulse, high one cycle after the edge that sampled a bad (0) stop bit.
- `busy`  output  1: high while the state is not IDLE.

## Operation
- States: IDLE, DATA, STOP.
- IDLE:
  - Edge with `shiftEN`=1 and `Q`=0 (start bit): go to DATA, bit counter := 0.
  - `Q`=1 or `shiftEN`=0: stay in IDLE.
- DATA, on each edge with `shiftEN`=1:
  - Shift register := {`Q`, shreg[DATA_WIDTH-1:1]}, i.e. right shift with new bit at the MSB. After DATA_WIDTH bits, the first received bit sits at bit 0.
  - Counter increments.
  - On the edge where counter == DATA_WIDTH-1, go to STOP.
- STOP, on edge with `shiftEN`=1:
  - `Q`=1: `data` := shreg, `valid` := 1.
  - `Q`=0: `frame_err` := 1; `data` unchanged.
  - Either case: go to IDLE.
- `shiftEN`=0 in any state: state, counter, and shreg all hold. `valid` and `frame_err` are cleared every edge unless set as above, so each pulse lasts exactly one cycle even if `shiftEN` stays low.
- Counter width is clog2(DATA_WIDTH), minimum 1. It never wraps past DATA_WIDTH-1.
- Back-to-back frames: the enabled edge after STOP samples in IDLE, so a start bit immediately following a stop bit is accepted with no idle gap. Each frame is 1 start + DATA_WIDTH data + 1 stop enabled edges.
- Line held at 0 indefinitely (break): receives an all-zero word, then `frame_err`. It then re-triggers from IDLE on each enabled edge; this is expected behaviour, no special break detection.

## Timing
- Reset values: state IDLE, counter 0, shreg 0, `data` 0, `valid` 0, `frame_err` 0, `busy` 0.
- Reset mid-frame discards the partial frame immediately; no strobe is issued.
- With `shiftEN` constantly 1 and the start bit sampled at edge n:
  - Data bits are sampled at edges n+1 through n+DATA_WIDTH.
  - The stop bit is sampled at edge n+DATA_WIDTH+1.
  - `valid` or `frame_err` is high during the cycle after that edge (n+DATA_WIDTH+1 through n+DATA_WIDTH+2).
  - `busy` is high from after edge n until after edge n+DATA_WIDTH+1.
- Latency: start-bit sample edge to `valid` high is DATA_WIDTH+1 enabled edges. `data` changes on the same edge that raises `valid`.
- All outputs are registered; there is no combinational path from `Q` or `shiftEN` to any output.

## Structure
- Shared header holds the state encodings (IDLE=2'd0, DATA=2'd1, STOP=2'd2) and the default frame width constant. The upstream transmitter controller uses the same constants.
- One natural sub-module: `bitcnt`, an enable-gated counter with asynchronous active-high reset, a synchronous clear, and a terminal-count output. The FSM and shift register stay in the top module.
- Treat the unused state encoding 2'd3 as IDLE.

## Test plan
- **Reset idle:** assert `reset` with `Q`=1 and `shiftEN`=1 for 20 cycles → `busy`, `valid`, `frame_err` stay 0 and `data`=0.
- **Good frame:** with `shiftEN`=1, drive bits 0,1,1,0,1,1 (start, LSB-first 4'hB, stop) → `data`=4'hB, and `valid` is high for exactly one cycle, 5 edges after the start sample.
- **Framing error:** drive 0,1,0,1,0,0 (stop=0) → `frame_err` pulses once, `valid` stays 0, and `data` keeps its previous value (4'hB).
- **Gated strobe:** send frame 4'h6 with `shiftEN` high only every third cycle, with `Q` toggling randomly on disabled cycles → `data`=4'h6 and one `valid` pulse, exactly one cycle wide.
- **Back-to-back:** send frames 4'hA then 4'h5 with no idle gap → two `valid` pulses exactly 6 edges apart, with `data` reading 4'hA then 4'h5.
- **Reset mid-frame:** assert `reset` after the 2nd data bit, release it, then send 4'h3 → no strobe from the aborted frame, then `data`=4'h3 with a single `valid`.
